otter_mem_burst: RTL and testbench

Parametrised successor to the OTTER data-memory block: a single-clock, byte-addressable BRAM data memory with sized/signed loads, byte-lane stores, memory-mapped IO decode, and a line-fill burst port that streams LINE_WORDS consecutive words to a data cache under valid/ready backpressure. It sits between the OTTER core's data port, the IO bus and the data-cache refill FSM. It also reports misaligned accesses, and it stalls the core while a burst owns the array.

---
 rtl/otter_mem_pkg.sv | 32 +++
 rtl/otter_mem_sizer.sv | 36 +++
 rtl/otter_mem_burst.sv | 233 +++++++++++++++++++++++
 tb/tb_otter_mem_burst.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER burst-capable data memory.
// Access sizes, fill FSM states and the byte-lane mask used by stores and alignment checks.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fill_state_t;

  localparam int unsigned IDX_W = 4;

  // An all-zero mask marks a misaligned or illegal-size access.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      BYTE:    mask = 4'b0001 << offset;
      HALF:    mask = offset[0] ? 4'b0000 : (4'b0011 << offset);
      WORD:    mask = (offset == 2'd0) ? 4'b1111 : 4'b0000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/otter_mem_sizer.sv
// Combinational load extractor: picks the addressed byte/half/word out of a 32-bit
// array word and zero- or sign-extends it; illegal size/offset pairs yield zero.
module otter_mem_sizer
  import otter_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {offset_i, 3'b000};
    data_o  = 32'h0000_0000;
    case (size_i)
      BYTE: begin
        if (unsigned_i) data_o = {24'h00_0000, shifted[7:0]};
        else            data_o = {{24{shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        if (offset_i[0])     data_o = 32'h0000_0000;
        else if (unsigned_i) data_o = {16'h0000, shifted[15:0]};
        else                 data_o = {{16{shifted[15]}}, shifted[15:0]};
      end
      WORD: begin
        if (offset_i == 2'd0) data_o = word_i;
        else                  data_o = 32'h0000_0000;
      end
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/otter_mem_burst.sv
// OTTER data memory with sized loads, byte-lane stores, IO decode and a
// valid/ready line-fill burst port that owns the array while a burst is in flight.
module otter_mem_burst
  import otter_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LINE_WORDS  = 4,
  parameter logic [31:0] IO_BASE     = 32'h0001_0000,
  parameter string       INIT_FILE   = "performance.mem"
) (
  input  logic        MEM_CLK,
  input  logic        RST_N,
  input  logic        MEM_RDEN2,
  input  logic        MEM_WE2,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_SIGN,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_BUSY,
  output logic        MEM_ERR,
  input  logic [31:0] IO_IN,
  output logic        IO_WR,
  input  logic        FILL_REQ,
  input  logic [31:0] FILL_ADDR,
  output logic        FILL_VALID,
  input  logic        FILL_READY,
  output logic [31:0] FILL_DATA,
  output logic [3:0]  FILL_IDX,
  output logic        FILL_LAST
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  fill_state_t      state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_io_q, rd_io_d;
  logic [1:0]       cap_size_q, cap_size_d;
  logic             cap_sign_q, cap_sign_d;
  logic [1:0]       cap_off_q, cap_off_d;
  logic [31:0]      io_data_q, io_data_d;
  logic [31:0]      dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             fvalid_q, fvalid_d;
  logic [31:0]      fdata_q, fdata_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic             flast_q, flast_d;

  logic             is_io;
  logic             busy;
  logic [3:0]       core_mask;
  logic             core_legal;
  logic             core_req;
  logic             arr_wr_en;
  logic             arr_rd_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    arr_rd_addr;
  logic [31:0]      wdata_lanes;
  logic             out_free;
  logic             issue;
  logic [31:0]      sized;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{FILL_ADDR[31:2+AW], FILL_ADDR[1:0]};

  always_comb begin
    busy        = (state_q != IDLE);
    is_io       = (MEM_ADDR2 >= IO_BASE);
    core_mask   = lane_mask(MEM_SIZE, MEM_ADDR2[1:0]);
    core_legal  = (core_mask != 4'b0000);
    core_req    = !busy && !is_io && (MEM_RDEN2 || MEM_WE2);
    arr_wr_en   = core_req && MEM_WE2 && core_legal;
    wr_addr     = MEM_ADDR2[2 +: AW];
    out_free    = !fvalid_q || FILL_READY;
    issue       = (state_q == FETCH) && (!pend_q || out_free);
    arr_rd_en   = issue || (core_req && MEM_RDEN2 && core_legal);
    arr_rd_addr = issue ? (base_q + AW'(issue_idx_q)) : wr_addr;
    case (MEM_SIZE)
      BYTE:    wdata_lanes = {4{MEM_DIN2[7:0]}};
      HALF:    wdata_lanes = {2{MEM_DIN2[15:0]}};
      default: wdata_lanes = MEM_DIN2;
    endcase
  end

  assign IO_WR = MEM_WE2 && is_io;

  // Array contents have no reset so they survive RST_N; the read register is the BRAM output latch.
  always_ff @(posedge MEM_CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (arr_wr_en && core_mask[b]) mem_q[wr_addr][8*b +: 8] <= wdata_lanes[8*b +: 8];
    end
    if (arr_rd_en) rdata_q <= mem_q[arr_rd_addr];
  end

  otter_mem_sizer u_sizer (
    .word_i     (rdata_q),
    .size_i     (cap_size_q),
    .unsigned_i (cap_sign_q),
    .offset_i   (cap_off_q),
    .data_o     (sized)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_idx_d = issue_idx_q;
    pend_d      = pend_q;
    pend_idx_d  = pend_idx_q;
    fvalid_d    = fvalid_q;
    fdata_d     = fdata_q;
    fidx_d      = fidx_q;
    flast_d     = flast_q;

    case (state_q)
      IDLE: begin
        if (FILL_REQ) begin
          state_d     = FETCH;
          base_d      = FILL_ADDR[2 +: AW] & ~AW'(LINE_WORDS - 1);
          issue_idx_d = {IDX_W{1'b0}};
        end
      end
      FETCH: begin
        if (issue) begin
          issue_idx_d = issue_idx_q + 4'd1;
          if (issue_idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fvalid_q && flast_q && FILL_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Two-slot pipeline: the array read register feeds the output beat register.
    if (out_free) begin
      fvalid_d = pend_q;
      if (pend_q) begin
        fdata_d = rdata_q;
        fidx_d  = pend_idx_q;
        flast_d = (pend_idx_q == LAST_IDX);
      end else begin
        flast_d = 1'b0;
      end
    end
    if (issue) begin
      pend_d     = 1'b1;
      pend_idx_d = issue_idx_q;
    end else if (out_free) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    rd_pend_d  = core_req && MEM_RDEN2;
    rd_io_d    = MEM_RDEN2 && is_io;
    cap_size_d = cap_size_q;
    cap_sign_d = cap_sign_q;
    cap_off_d  = cap_off_q;
    io_data_d  = io_data_q;
    dout_d     = dout_q;
    busy_d     = (state_d != IDLE);
    err_d      = core_req && !core_legal;
    if (core_req && MEM_RDEN2) begin
      cap_size_d = MEM_SIZE;
      cap_sign_d = MEM_SIGN;
      cap_off_d  = MEM_ADDR2[1:0];
    end
    if (rd_io_d) io_data_d = IO_IN;
    if (rd_io_q)        dout_d = io_data_q;
    else if (rd_pend_q) dout_d = sized;
  end

  // All control and output state, cleared asynchronously so a burst aborts without a partial beat.
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      base_q      <= {AW{1'b0}};
      issue_idx_q <= {IDX_W{1'b0}};
      pend_q      <= 1'b0;
      pend_idx_q  <= {IDX_W{1'b0}};
      rd_pend_q   <= 1'b0;
      rd_io_q     <= 1'b0;
      cap_size_q  <= 2'd0;
      cap_sign_q  <= 1'b0;
      cap_off_q   <= 2'd0;
      io_data_q   <= 32'h0000_0000;
      dout_q      <= 32'h0000_0000;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      fvalid_q    <= 1'b0;
      fdata_q     <= 32'h0000_0000;
      fidx_q      <= {IDX_W{1'b0}};
      flast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_idx_q <= issue_idx_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      rd_pend_q   <= rd_pend_d;
      rd_io_q     <= rd_io_d;
      cap_size_q  <= cap_size_d;
      cap_sign_q  <= cap_sign_d;
      cap_off_q   <= cap_off_d;
      io_data_q   <= io_data_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      fvalid_q    <= fvalid_d;
      fdata_q     <= fdata_d;
      fidx_q      <= fidx_d;
      flast_q     <= flast_d;
    end
  end

  assign MEM_DOUT2  = dout_q;
  assign MEM_BUSY   = busy_q;
  assign MEM_ERR    = err_q;
  assign FILL_VALID = fvalid_q;
  assign FILL_DATA  = fdata_q;
  assign FILL_IDX   = fidx_q;
  assign FILL_LAST  = flast_q;

endmodule

// File: tb/tb_otter_mem_burst.sv
// Directed self-checking bench for otter_mem_burst: sized loads/stores, IO decode,
// line-fill bursts with and without backpressure, and reset during a burst.
module tb_otter_mem_burst;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [31:0] MEM_ADDR2, MEM_DIN2, IO_IN, FILL_ADDR;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_DOUT2, FILL_DATA;
  logic        MEM_BUSY, MEM_ERR, IO_WR, FILL_REQ, FILL_VALID, FILL_READY, FILL_LAST;
  logic [3:0]  FILL_IDX;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  otter_mem_burst #(
    .DEPTH_WORDS (4096),
    .LINE_WORDS  (4),
    .IO_BASE     (32'h0001_0000),
    .INIT_FILE   ("")
  ) dut (
    .MEM_CLK    (clk),
    .RST_N      (RST_N),
    .MEM_RDEN2  (MEM_RDEN2),
    .MEM_WE2    (MEM_WE2),
    .MEM_ADDR2  (MEM_ADDR2),
    .MEM_DIN2   (MEM_DIN2),
    .MEM_SIZE   (MEM_SIZE),
    .MEM_SIGN   (MEM_SIGN),
    .MEM_DOUT2  (MEM_DOUT2),
    .MEM_BUSY   (MEM_BUSY),
    .MEM_ERR    (MEM_ERR),
    .IO_IN      (IO_IN),
    .IO_WR      (IO_WR),
    .FILL_REQ   (FILL_REQ),
    .FILL_ADDR  (FILL_ADDR),
    .FILL_VALID (FILL_VALID),
    .FILL_READY (FILL_READY),
    .FILL_DATA  (FILL_DATA),
    .FILL_IDX   (FILL_IDX),
    .FILL_LAST  (FILL_LAST)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    MEM_ADDR2 = addr;
    MEM_DIN2  = data;
    MEM_SIZE  = size;
    MEM_WE2   = 1'b1;
    tick();
    MEM_WE2   = 1'b0;
  endtask

  // Request inputs are scrambled after the request edge to prove they were captured.
  task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      output logic [31:0] res);
    MEM_ADDR2 = addr;
    MEM_SIZE  = size;
    MEM_SIGN  = uns;
    MEM_RDEN2 = 1'b1;
    tick();
    MEM_RDEN2 = 1'b0;
    MEM_ADDR2 = ~addr;
    MEM_SIZE  = 2'd3;
    MEM_SIGN  = ~uns;
    tick();
    res = MEM_DOUT2;
  endtask

  logic [31:0] rd;
  logic [31:0] exp_beat [4];
  logic [31:0] got_data [8];
  logic [3:0]  got_idx  [8];
  int          pat [4] = '{1, 0, 0, 1};
  int          beats;
  logic        prev_stall, err_seen, found;
  logic [31:0] hold_data;
  logic [3:0]  hold_idx;

  initial begin
    RST_N = 1'b0; MEM_RDEN2 = 1'b0; MEM_WE2 = 1'b0; MEM_SIGN = 1'b0;
    MEM_ADDR2 = 32'h0; MEM_DIN2 = 32'h0; MEM_SIZE = 2'd2; IO_IN = 32'h0;
    FILL_REQ = 1'b0; FILL_ADDR = 32'h0; FILL_READY = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dout", MEM_DOUT2, 32'h0);
    check_eq("rst_busy", {31'h0, MEM_BUSY}, 32'h0);
    check_eq("rst_err", {31'h0, MEM_ERR}, 32'h0);
    check_eq("rst_iowr", {31'h0, IO_WR}, 32'h0);
    check_eq("rst_fvalid", {31'h0, FILL_VALID}, 32'h0);
    check_eq("rst_fdata", FILL_DATA, 32'h0);
    check_eq("rst_fidx", {28'h0, FILL_IDX}, 32'h0);
    check_eq("rst_flast", {31'h0, FILL_LAST}, 32'h0);
    RST_N = 1'b1;
    tick();

    // Sized loads on a stored word.
    store(32'h100, 32'hDEAD_BEEF, 2'd2);
    check_eq("sw_err", {31'h0, MEM_ERR}, 32'h0);
    load(32'h100, 2'd2, 1'b0, rd); check_eq("lw_100", rd, 32'hDEAD_BEEF);
    load(32'h103, 2'd0, 1'b0, rd); check_eq("lb_103", rd, 32'hFFFF_FFDE);
    load(32'h103, 2'd0, 1'b1, rd); check_eq("lbu_103", rd, 32'h0000_00DE);
    load(32'h102, 2'd1, 1'b0, rd); check_eq("lh_102", rd, 32'hFFFF_DEAD);
    load(32'h100, 2'd1, 1'b1, rd); check_eq("lhu_100", rd, 32'h0000_BEEF);
    load(32'h101, 2'd0, 1'b0, rd); check_eq("lb_101", rd, 32'hFFFF_FFBE);

    // Byte store and misaligned half store.
    store(32'h101, 32'h0000_0055, 2'd0);
    load(32'h100, 2'd2, 1'b0, rd); check_eq("sb_merge", rd, 32'hDEAD_55EF);
    store(32'h103, 32'h0000_1234, 2'd1);
    check_eq("sh_mis_err", {31'h0, MEM_ERR}, 32'h1);
    tick();
    check_eq("err_pulse_end", {31'h0, MEM_ERR}, 32'h0);
    load(32'h100, 2'd2, 1'b0, rd); check_eq("sh_mis_nowrite", rd, 32'hDEAD_55EF);
    load(32'h103, 2'd1, 1'b0, rd); check_eq("lh_mis_zero", rd, 32'h0);
    load(32'h100, 2'd3, 1'b1, rd); check_eq("size3_zero", rd, 32'h0);

    // IO write does not touch the aliased array word; IO read returns IO_IN unsized.
    store(32'h4, 32'h1111_1111, 2'd2);
    MEM_ADDR2 = 32'h0001_0004; MEM_DIN2 = 32'hA5; MEM_SIZE = 2'd0; MEM_WE2 = 1'b1;
    #1;
    check_eq("io_wr_high", {31'h0, IO_WR}, 32'h1);
    tick();
    MEM_WE2 = 1'b0;
    #1;
    check_eq("io_wr_low", {31'h0, IO_WR}, 32'h0);
    load(32'h4, 2'd2, 1'b0, rd); check_eq("io_no_array", rd, 32'h1111_1111);
    IO_IN = 32'h1234;
    MEM_ADDR2 = 32'h0001_0000; MEM_SIZE = 2'd0; MEM_SIGN = 1'b0; MEM_RDEN2 = 1'b1;
    tick();
    MEM_RDEN2 = 1'b0; IO_IN = 32'hFFFF_0000;
    tick();
    check_eq("io_read", MEM_DOUT2, 32'h0000_1234);

    // Burst with ready held high; a same-cycle core write must be visible.
    for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd2);
    exp_beat = '{32'hA000_0000, 32'hA000_0001, 32'hCAFE_F00D, 32'hA000_0003};
    FILL_ADDR = 32'h4C; FILL_REQ = 1'b1; FILL_READY = 1'b1;
    MEM_ADDR2 = 32'h48; MEM_DIN2 = 32'hCAFE_F00D; MEM_SIZE = 2'd2; MEM_WE2 = 1'b1;
    tick();
    FILL_REQ = 1'b0; MEM_WE2 = 1'b0;
    check_eq("b1_busy_k", {31'h0, MEM_BUSY}, 32'h1);
    check_eq("b1_valid_k", {31'h0, FILL_VALID}, 32'h0);
    tick();
    check_eq("b1_valid_k1", {31'h0, FILL_VALID}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("b1_valid", {31'h0, FILL_VALID}, 32'h1);
      check_eq("b1_idx", {28'h0, FILL_IDX}, 32'(i));
      check_eq("b1_data", FILL_DATA, exp_beat[i]);
      check_eq("b1_last", {31'h0, FILL_LAST}, (i == 3) ? 32'h1 : 32'h0);
      check_eq("b1_busy", {31'h0, MEM_BUSY}, 32'h1);
    end
    tick();
    check_eq("b1_valid_end", {31'h0, FILL_VALID}, 32'h0);
    check_eq("b1_busy_end", {31'h0, MEM_BUSY}, 32'h0);

    // Burst under 1,0,0,1 backpressure with core writes attempted while busy.
    FILL_ADDR = 32'h40; FILL_REQ = 1'b1; FILL_READY = 1'b1;
    tick();
    FILL_REQ = 1'b0;
    beats = 0; prev_stall = 1'b0; err_seen = 1'b0; hold_data = 32'h0; hold_idx = 4'h0;
    for (int c = 0; c < 60 && !(beats >= 4 && !MEM_BUSY); c++) begin
      FILL_READY = (pat[c % 4] != 0);
      MEM_WE2 = (c == 1) || (c == 2);
      MEM_ADDR2 = (c == 2) ? 32'h42 : 32'h40;
      MEM_DIN2 = 32'hBAD0_BAD0; MEM_SIZE = 2'd2;
      if (prev_stall) begin
        check_eq("stall_data", FILL_DATA, hold_data);
        check_eq("stall_idx", {28'h0, FILL_IDX}, {28'h0, hold_idx});
      end
      if (FILL_VALID && FILL_READY) begin
        if (beats < 8) begin
          got_data[beats] = FILL_DATA;
          got_idx[beats]  = FILL_IDX;
        end
        beats++;
      end
      prev_stall = FILL_VALID && !FILL_READY;
      hold_data = FILL_DATA; hold_idx = FILL_IDX;
      err_seen = err_seen | MEM_ERR;
      tick();
    end
    MEM_WE2 = 1'b0; FILL_READY = 1'b1;
    check_eq("b2_beats", 32'(beats), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("b2_idx", {28'h0, got_idx[i]}, 32'(i));
      check_eq("b2_data", got_data[i], exp_beat[i]);
    end
    check_eq("b2_no_err", {31'h0, err_seen}, 32'h0);
    check_eq("b2_valid_end", {31'h0, FILL_VALID}, 32'h0);
    load(32'h40, 2'd2, 1'b0, rd); check_eq("busy_write_ignored", rd, 32'hA000_0000);

    // Reset asserted while beat 2 is presented.
    FILL_ADDR = 32'h40; FILL_REQ = 1'b1; FILL_READY = 1'b1;
    tick();
    FILL_REQ = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (FILL_VALID && FILL_IDX == 4'd2) found = 1'b1;
      else tick();
    end
    check_eq("rst_reach_beat2", {31'h0, found}, 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check_eq("rstmid_valid", {31'h0, FILL_VALID}, 32'h0);
    check_eq("rstmid_busy", {31'h0, MEM_BUSY}, 32'h0);
    check_eq("rstmid_idx", {28'h0, FILL_IDX}, 32'h0);
    @(negedge clk); @(negedge clk);
    RST_N = 1'b1;
    tick();
    check_eq("post_rst_valid", {31'h0, FILL_VALID}, 32'h0);
    FILL_REQ = 1'b1;
    tick();
    FILL_REQ = 1'b0;
    tick(); tick();
    check_eq("restart_valid", {31'h0, FILL_VALID}, 32'h1);
    check_eq("restart_idx", {28'h0, FILL_IDX}, 32'h0);
    check_eq("restart_data", FILL_DATA, 32'hA000_0000);
    repeat (6) tick();
    check_eq("restart_done", {31'h0, MEM_BUSY}, 32'h0);
    load(32'h48, 2'd2, 1'b0, rd); check_eq("array_retained", rd, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
